// File: rtl/ram_req_bridge_if.sv
// Upstream request/response bus of the RAM request bridge.
// The master side issues requests and consumes responses; the bridge is the slave.
interface ram_req_bridge_if;
   logic        req;
   logic        wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic        resp_ready;
   logic [31:0] rdata;
   logic        resp_err;

   modport master (
      output req, wr, size, addr, wdata, resp_ready,
      input  addr_ok, data_ok, rdata, resp_err
   );

   modport slave (
      input  req, wr, size, addr, wdata, resp_ready,
      output addr_ok, data_ok, rdata, resp_err
   );
endinterface

// File: rtl/ram_req_bridge.sv
// Bridges a byte-addressed request/response bus onto a synchronous word RAM.
// Accepted requests drive the RAM in the same cycle; one cycle later a response
// {err, data} is pushed into a small FIFO that upstream drains in order.
module ram_req_bridge #(
   parameter int ADDR_WIDTH = 16,
   parameter int RESP_DEPTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   ram_req_bridge_if.slave       up,
   output logic                  ram_en,
   output logic [3:0]            ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_wdata,
   input  logic [31:0]           ram_rdata
);

   localparam int PTR_W = $clog2(RESP_DEPTH);

   function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'd0:    return 1'b1;
         2'd1:    return ~a[0];
         2'd2:    return (a == 2'b00);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] byte_we(input logic [1:0] size, input logic [1:0] a);
      case (size)
         2'd0:    return 4'b0001 << a;
         2'd1:    return 4'b0011 << {a[1], 1'b0};
         2'd2:    return 4'b1111;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // vld_p1 is the "pending" flag: a request was accepted last cycle and its
   // response is being pushed this cycle.
   logic                vld_p1;
   logic                err_p1;
   logic                rd_p1;
   logic [2:0]          count;
   logic [2:0]          inflight;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [31:0]         mem_data [RESP_DEPTH];
   logic                mem_err  [RESP_DEPTH];
   logic                accept;
   logic                aligned;
   logic                push;
   logic                pop;
   logic                data_ok;
   logic [31:0]         push_data;
   logic                unused_addr_hi;

   assign unused_addr_hi = ^up.addr[31:ADDR_WIDTH+2];

   // Acceptance only looks at registered occupancy, never at resp_ready.
   assign inflight   = count + {2'b00, vld_p1};
   assign up.addr_ok = !reset && (inflight < 3'(RESP_DEPTH));
   assign accept     = up.req && up.addr_ok;
   assign aligned    = is_aligned(up.size, up.addr[1:0]);

   // Stage p0: RAM is driven combinationally in the accept cycle; bad accesses never touch it.
   assign ram_en    = accept && aligned && !up.wr;
   assign ram_we    = (accept && aligned && up.wr) ? byte_we(up.size, up.addr[1:0]) : 4'b0000;
   assign ram_addr  = up.addr[ADDR_WIDTH+1:2];
   assign ram_wdata = up.wdata;

   // Stage p1: read data returns from the RAM and is captured into the FIFO.
   assign push      = vld_p1;
   assign push_data = (rd_p1 && !err_p1) ? ram_rdata : 32'd0;

   assign data_ok     = !reset && (count != 3'd0);
   assign pop         = data_ok && up.resp_ready;
   assign up.data_ok  = data_ok;
   assign up.rdata    = data_ok ? mem_data[rd_ptr] : 32'd0;
   assign up.resp_err = data_ok ? mem_err[rd_ptr]  : 1'b0;

   // Control state: pending flag, FIFO occupancy and pointers.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_p1 <= 1'b0;
         count  <= 3'd0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         vld_p1 <= accept;
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   // Request attributes carried into p1 alongside the pending flag.
   always_ff @(posedge clk) begin
      if (accept) begin
         err_p1 <= !aligned;
         rd_p1  <= !up.wr;
      end
   end

   // Response storage; entries are only meaningful while counted.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= push_data;
         mem_err[wr_ptr]  <= err_p1;
      end
   end

endmodule
